// File: rtl/core_dispatch_scoreboard_if.sv
`default_nettype none
// ============================================================================
// Module      : core_dispatch_scoreboard_pkg / core_dispatch_scoreboard_if
// Description : Decoded-instruction types and the dispatch <-> scoreboard
//               bundle (slot instructions, issue strobes, EU retire pulses,
//               source masks, pending-write masks and busy flags).
// Revision    : 1.0 - initial release
// ============================================================================

package core_dispatch_scoreboard_pkg;

    localparam int REG_W = 4;

    typedef logic [REG_W-1:0] reg_num;

    typedef struct packed {
        logic execute;
        logic branch;
        logic mul;
        logic ldst;
    } insn_ctrl;

    typedef struct packed {
        logic   writeback;
        reg_num rd;
        reg_num ra;
        reg_num rb;
        logic   uses_ra;
        logic   uses_rb;
    } insn_data;

    typedef struct packed {
        insn_ctrl ctrl;
        insn_data data;
    } insn_decode;

endpackage

interface core_dispatch_scoreboard_if #(
    parameter int NUM_REGS = 16
);
    import core_dispatch_scoreboard_pkg::*;

    insn_decode          cur_a;
    insn_decode          cur_b;
    logic                dispatch_a;
    logic                dispatch_b;
    logic                done_alu_a;
    logic                done_alu_b;
    logic                done_mul;
    logic                done_ldst;
    logic                done_branch;
    logic [NUM_REGS-1:0] mask_a_ra;
    logic [NUM_REGS-1:0] mask_a_rb;
    logic [NUM_REGS-1:0] mask_b_ra;
    logic [NUM_REGS-1:0] mask_b_rb;
    logic [NUM_REGS-1:0] mask_alu_a;
    logic [NUM_REGS-1:0] mask_alu_b;
    logic [NUM_REGS-1:0] mask_mul;
    logic [NUM_REGS-1:0] mask_ldst;
    logic [NUM_REGS-1:0] mask_branch;
    logic                busy_alu_a;
    logic                busy_alu_b;
    logic                busy_mul;
    logic                busy_ldst;
    logic                busy_branch;

    // Dispatch side: drives instructions, issue strobes and retire pulses.
    modport master (
        output cur_a, cur_b, dispatch_a, dispatch_b,
               done_alu_a, done_alu_b, done_mul, done_ldst, done_branch,
        input  mask_a_ra, mask_a_rb, mask_b_ra, mask_b_rb,
               mask_alu_a, mask_alu_b, mask_mul, mask_ldst, mask_branch,
               busy_alu_a, busy_alu_b, busy_mul, busy_ldst, busy_branch
    );

    // Scoreboard side.
    modport slave (
        input  cur_a, cur_b, dispatch_a, dispatch_b,
               done_alu_a, done_alu_b, done_mul, done_ldst, done_branch,
        output mask_a_ra, mask_a_rb, mask_b_ra, mask_b_rb,
               mask_alu_a, mask_alu_b, mask_mul, mask_ldst, mask_branch,
               busy_alu_a, busy_alu_b, busy_mul, busy_ldst, busy_branch
    );

endinterface
`default_nettype wire

// File: rtl/core_dispatch_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : core_dispatch_scoreboard
// Description : Per-EU register scoreboard for the dual-issue dispatch stage.
//               One tracker (valid + rd tag) per execution unit; set on a
//               writing issue, cleared on the EU retire pulse. Produces
//               one-hot pending-write masks, busy flags and the
//               combinational source-operand masks for hazard detection.
// Revision    : 1.0 - initial release
// ============================================================================

module core_dispatch_scoreboard #(
    parameter int NUM_REGS = 16
) (
    input  wire                        clk,
    input  wire                        rst,
    core_dispatch_scoreboard_if.slave  sb
);
    import core_dispatch_scoreboard_pkg::*;

    localparam int         c_TAG_W  = $clog2(NUM_REGS);
    localparam int         c_NUM_EU = 5;
    localparam logic [2:0] c_EU_ALU_A  = 3'd0;
    localparam logic [2:0] c_EU_ALU_B  = 3'd1;
    localparam logic [2:0] c_EU_MUL    = 3'd2;
    localparam logic [2:0] c_EU_LDST   = 3'd3;
    localparam logic [2:0] c_EU_BRANCH = 3'd4;
    localparam logic [NUM_REGS-1:0] c_ONE = {{(NUM_REGS-1){1'b0}}, 1'b1};

    // Steering priority: branch, then mul, then ldst, else the slot's own ALU.
    function automatic logic [2:0] steer(input insn_decode insn, input logic slot_b);
        if (insn.ctrl.branch)   return c_EU_BRANCH;
        else if (insn.ctrl.mul) return c_EU_MUL;
        else if (insn.ctrl.ldst) return c_EU_LDST;
        else if (slot_b)        return c_EU_ALU_B;
        else                    return c_EU_ALU_A;
    endfunction

    logic [2:0]          w_eu_a;
    logic [2:0]          w_eu_b;
    logic                w_issue_a;
    logic                w_issue_b;
    logic [c_NUM_EU-1:0] w_set_a;
    logic [c_NUM_EU-1:0] w_set_b;
    logic [c_NUM_EU-1:0] w_done;
    logic [c_NUM_EU-1:0] r_valid;
    logic [c_TAG_W-1:0]  r_tag     [c_NUM_EU];
    logic [NUM_REGS-1:0] w_eu_mask [c_NUM_EU];

    assign w_eu_a    = steer(sb.cur_a, 1'b0);
    assign w_eu_b    = steer(sb.cur_b, 1'b1);
    assign w_issue_a = sb.dispatch_a && sb.cur_a.ctrl.execute && sb.cur_a.data.writeback;
    assign w_issue_b = sb.dispatch_b && sb.cur_b.ctrl.execute && sb.cur_b.data.writeback;
    assign w_done    = {sb.done_branch, sb.done_ldst, sb.done_mul,
                        sb.done_alu_b, sb.done_alu_a};

    // Decode which tracker each slot writes this cycle.
    always_comb begin
        w_set_a = '0;
        w_set_b = '0;
        if (w_issue_a) w_set_a[w_eu_a] = 1'b1;
        if (w_issue_b) w_set_b[w_eu_b] = 1'b1;
    end

    // Tracker update: reset beats everything, a set beats a concurrent retire,
    // and slot a beats slot b if both land on the same EU.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            for (int e = 0; e < c_NUM_EU; e++) begin
                r_tag[e] <= '0;
            end
        end else begin
            for (int e = 0; e < c_NUM_EU; e++) begin
                if (w_set_a[e]) begin
                    r_valid[e] <= 1'b1;
                    r_tag[e]   <= sb.cur_a.data.rd;
                end else if (w_set_b[e]) begin
                    r_valid[e] <= 1'b1;
                    r_tag[e]   <= sb.cur_b.data.rd;
                end else if (w_done[e]) begin
                    r_valid[e] <= 1'b0;
                end
            end
        end
    end

    generate
        for (genvar e = 0; e < c_NUM_EU; e++) begin : g_eu
            assign w_eu_mask[e] = r_valid[e] ? (c_ONE << r_tag[e]) : '0;

            // Hazard logic must never route both slots into one EU.
            a_no_dual_steer : assert property (@(posedge clk) disable iff (rst)
                !(w_set_a[e] && w_set_b[e]));

            // A busy EU may only be re-issued in the cycle it retires.
            a_no_overwrite : assert property (@(posedge clk) disable iff (rst)
                !((w_set_a[e] || w_set_b[e]) && r_valid[e] && !w_done[e]));
        end
    endgenerate

    assign sb.mask_alu_a  = w_eu_mask[c_EU_ALU_A];
    assign sb.mask_alu_b  = w_eu_mask[c_EU_ALU_B];
    assign sb.mask_mul    = w_eu_mask[c_EU_MUL];
    assign sb.mask_ldst   = w_eu_mask[c_EU_LDST];
    assign sb.mask_branch = w_eu_mask[c_EU_BRANCH];

    assign sb.busy_alu_a  = r_valid[c_EU_ALU_A];
    assign sb.busy_alu_b  = r_valid[c_EU_ALU_B];
    assign sb.busy_mul    = r_valid[c_EU_MUL];
    assign sb.busy_ldst   = r_valid[c_EU_LDST];
    assign sb.busy_branch = r_valid[c_EU_BRANCH];

    // Source-operand masks follow the current decode with no state.
    assign sb.mask_a_ra = sb.cur_a.data.uses_ra ? (c_ONE << sb.cur_a.data.ra) : '0;
    assign sb.mask_a_rb = sb.cur_a.data.uses_rb ? (c_ONE << sb.cur_a.data.rb) : '0;
    assign sb.mask_b_ra = sb.cur_b.data.uses_ra ? (c_ONE << sb.cur_b.data.ra) : '0;
    assign sb.mask_b_rb = sb.cur_b.data.uses_rb ? (c_ONE << sb.cur_b.data.rb) : '0;

endmodule
`default_nettype wire

// File: tb/tb_core_dispatch_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_core_dispatch_scoreboard
// Description : Self-checking bench for core_dispatch_scoreboard. A driver
//               issues directed then random legal traffic and queues the
//               expected outputs from a map-based reference model; a monitor
//               pops and compares on every falling edge.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_core_dispatch_scoreboard;
    import core_dispatch_scoreboard_pkg::*;

    logic clk;
    logic rst;

    core_dispatch_scoreboard_if #(.NUM_REGS(16)) sb ();

    core_dispatch_scoreboard #(.NUM_REGS(16)) dut (
        .clk (clk),
        .rst (rst),
        .sb  (sb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected view of the outputs during one cycle.
    typedef struct packed {
        bit              chk_state;
        logic [3:0][15:0] src;
        logic [4:0][15:0] eu;
        logic [4:0]       busy;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: EU index -> pending destination register.
    int   pend[int];
    bit   model_known = 1'b0;

    // EU numbering: 0 alu_a, 1 alu_b, 2 mul, 3 ldst, 4 branch.
    function automatic int eu_of(input insn_decode i, input bit slot_b);
        if (i.ctrl.branch) return 4;
        if (i.ctrl.mul)    return 2;
        if (i.ctrl.ldst)   return 3;
        return slot_b ? 1 : 0;
    endfunction

    function automatic logic [15:0] onehot(input bit en, input int idx);
        logic [15:0] m;
        m = 16'd0;
        if (en) m[idx] = 1'b1;
        return m;
    endfunction

    function automatic insn_decode mk(input bit ex, input bit br, input bit mu,
                                      input bit ld, input bit wb, input int rd,
                                      input int ra, input int rb,
                                      input bit ura, input bit urb);
        insn_decode i;
        i.ctrl.execute   = ex;
        i.ctrl.branch    = br;
        i.ctrl.mul       = mu;
        i.ctrl.ldst      = ld;
        i.data.writeback = wb;
        i.data.rd        = 4'(rd);
        i.data.ra        = 4'(ra);
        i.data.rb        = 4'(rb);
        i.data.uses_ra   = ura;
        i.data.uses_rb   = urb;
        return i;
    endfunction

    // Drive one cycle of stimulus, queue its expected outputs, advance model.
    task automatic cyc(input bit r, input insn_decode a, input insn_decode b,
                       input bit da, input bit db, input logic [4:0] done);
        exp_t e;
        bit   ia;
        bit   ib;
        int   ea;
        int   eb;
        @(posedge clk);
        #1;
        rst            = r;
        sb.cur_a       = a;
        sb.cur_b       = b;
        sb.dispatch_a  = da;
        sb.dispatch_b  = db;
        sb.done_alu_a  = done[0];
        sb.done_alu_b  = done[1];
        sb.done_mul    = done[2];
        sb.done_ldst   = done[3];
        sb.done_branch = done[4];

        e.chk_state = model_known;
        e.src[0] = onehot(a.data.uses_ra, int'(a.data.ra));
        e.src[1] = onehot(a.data.uses_rb, int'(a.data.rb));
        e.src[2] = onehot(b.data.uses_ra, int'(b.data.ra));
        e.src[3] = onehot(b.data.uses_rb, int'(b.data.rb));
        for (int k = 0; k < 5; k++) begin
            e.eu[k]   = onehot(pend.exists(k), pend.exists(k) ? pend[k] : 0);
            e.busy[k] = pend.exists(k);
        end
        expq.push_back(e);

        if (r) begin
            pend.delete();
            model_known = 1'b1;
        end else begin
            for (int k = 0; k < 5; k++) begin
                if (done[k] && pend.exists(k)) pend.delete(k);
            end
            ia = da && a.ctrl.execute && a.data.writeback;
            ib = db && b.ctrl.execute && b.data.writeback;
            ea = eu_of(a, 1'b0);
            eb = eu_of(b, 1'b1);
            if (ib && !(ia && ea == eb)) pend[eb] = int'(b.data.rd);
            if (ia) pend[ea] = int'(a.data.rd);
        end
    endtask

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, got, exp, $time);
        end
    endtask

    // Monitor: compare DUT outputs against the queued expectation each cycle.
    initial begin
        exp_t        e;
        logic [15:0] g_eu [5];
        logic [4:0]  g_busy;
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                check("mask_a_ra", sb.mask_a_ra, e.src[0]);
                check("mask_a_rb", sb.mask_a_rb, e.src[1]);
                check("mask_b_ra", sb.mask_b_ra, e.src[2]);
                check("mask_b_rb", sb.mask_b_rb, e.src[3]);
                if (e.chk_state) begin
                    g_eu[0] = sb.mask_alu_a;
                    g_eu[1] = sb.mask_alu_b;
                    g_eu[2] = sb.mask_mul;
                    g_eu[3] = sb.mask_ldst;
                    g_eu[4] = sb.mask_branch;
                    g_busy  = {sb.busy_branch, sb.busy_ldst, sb.busy_mul,
                               sb.busy_alu_b, sb.busy_alu_a};
                    for (int k = 0; k < 5; k++) begin
                        check($sformatf("mask_eu%0d", k), g_eu[k], e.eu[k]);
                        check($sformatf("busy_eu%0d", k), 16'(g_busy[k]), 16'(e.busy[k]));
                    end
                end
            end
        end
    end

    // Driver: directed scenarios, then random legal traffic.
    initial begin
        insn_decode nop;
        insn_decode a;
        insn_decode b;
        bit         r;
        bit         da;
        bit         db;
        logic [4:0] dn;
        int         ea;
        int         eb;
        int         waited;

        nop = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        a   = mk(1, 0, 0, 0, 1, 5, 0, 0, 0, 0);

        // Reset held two cycles while slot a tries to issue a writing op.
        cyc(1, a, nop, 1, 0, 5'b0);
        cyc(1, a, nop, 1, 0, 5'b0);
        cyc(0, nop, nop, 0, 0, 5'b0);

        // ALU issue rd=5 then retire.
        cyc(0, a, nop, 1, 0, 5'b0);
        cyc(0, nop, nop, 0, 0, 5'b00001);
        cyc(0, nop, nop, 0, 0, 5'b0);

        // Dual issue: mul rd=3 in slot a, ALU rd=12 in slot b.
        cyc(0, mk(1, 0, 1, 0, 1, 3, 1, 2, 1, 1), mk(1, 0, 0, 0, 1, 12, 3, 4, 0, 1), 1, 1, 5'b0);
        cyc(0, nop, nop, 0, 0, 5'b00110);
        // Slot b ALU without writeback leaves alu_b idle.
        cyc(0, nop, mk(1, 0, 0, 0, 0, 6, 0, 0, 0, 0), 0, 1, 5'b0);
        cyc(0, nop, nop, 0, 0, 5'b0);

        // Back-to-back: rd=2 pending, retire and reissue rd=7 together.
        cyc(0, mk(1, 0, 0, 0, 1, 2, 0, 0, 0, 0), nop, 1, 0, 5'b0);
        cyc(0, mk(1, 0, 0, 0, 1, 7, 0, 0, 0, 0), nop, 1, 0, 5'b00001);
        cyc(0, nop, nop, 0, 0, 5'b00001);

        // Source masks on slot b and a spurious ldst retire while idle.
        cyc(0, nop, mk(0, 0, 0, 0, 0, 0, 9, 4, 1, 0), 0, 0, 5'b01000);
        cyc(0, nop, nop, 0, 0, 5'b0);

        // Branch has priority over ldst in steering.
        cyc(0, nop, mk(1, 1, 0, 1, 1, 1, 0, 0, 0, 0), 0, 1, 5'b0);
        cyc(0, nop, nop, 0, 0, 5'b10000);

        // Same rd pending in two EUs.
        cyc(0, mk(1, 0, 0, 1, 1, 8, 0, 0, 0, 0), mk(1, 0, 0, 0, 1, 8, 0, 0, 0, 0), 1, 1, 5'b0);
        cyc(0, nop, nop, 0, 0, 5'b01000);
        cyc(0, nop, nop, 0, 0, 5'b00010);

        // Random legal traffic with occasional mid-run resets.
        for (int n = 0; n < 400; n++) begin
            r  = ($urandom_range(0, 49) == 0);
            a  = mk($urandom_range(0, 9) < 8, $urandom_range(0, 4) == 0,
                    $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
                    $urandom_range(0, 9) < 8, $urandom_range(0, 15),
                    $urandom_range(0, 15), $urandom_range(0, 15),
                    $urandom_range(0, 1), $urandom_range(0, 1));
            b  = mk($urandom_range(0, 9) < 8, $urandom_range(0, 4) == 0,
                    $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
                    $urandom_range(0, 9) < 8, $urandom_range(0, 15),
                    $urandom_range(0, 15), $urandom_range(0, 15),
                    $urandom_range(0, 1), $urandom_range(0, 1));
            da = $urandom_range(0, 1);
            db = $urandom_range(0, 1);
            dn = 5'($urandom_range(0, 31)) & 5'($urandom_range(0, 31));
            ea = eu_of(a, 1'b0);
            eb = eu_of(b, 1'b1);
            // Keep the stimulus legal: no shared EU, no issue into a busy EU
            // unless it retires in the same cycle.
            if (da && db && a.ctrl.execute && a.data.writeback &&
                b.ctrl.execute && b.data.writeback && ea == eb) db = 1'b0;
            if (da && a.ctrl.execute && a.data.writeback && pend.exists(ea)) dn[ea] = 1'b1;
            if (db && b.ctrl.execute && b.data.writeback && pend.exists(eb)) dn[eb] = 1'b1;
            cyc(r, a, b, da, db, dn);
        end
        cyc(0, nop, nop, 0, 0, 5'b0);

        waited = 0;
        while (expq.size() > 0 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (expq.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending expectations required 0", expq.size());
        end
        @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
